// File: rtl/rx_fc_pkg.sv
// Shared constants and types for the receive-side VC credit buffer.
package rx_fc_pkg;
  localparam int CREDIT_W_DEF = 12;
  localparam int CLS_W_DEF    = 3;

  localparam logic [CLS_W_DEF-1:0] PH   = 3'd0;
  localparam logic [CLS_W_DEF-1:0] PD   = 3'd1;
  localparam logic [CLS_W_DEF-1:0] NPH  = 3'd2;
  localparam logic [CLS_W_DEF-1:0] NPD  = 3'd3;
  localparam logic [CLS_W_DEF-1:0] CPLH = 3'd4;
  localparam logic [CLS_W_DEF-1:0] CPLD = 3'd5;

  typedef struct packed {
    logic [CLS_W_DEF-1:0]    cls;
    logic [CREDIT_W_DEF-1:0] limit;
  } updfc_t;

  typedef enum logic {FC_IDLE, FC_OFFER} fc_state_e;
endpackage

// File: rtl/rx_class_fifo.sv
// Single-class synchronous FIFO with registered read data and wrap-bit pointers.
module rx_class_fifo #(
  parameter int DATA_W = 160,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              pop_ack_o,
  output logic              drop_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, rptr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              do_push;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ack_o = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push_i && (!full_o || pop_ack_o);
  assign drop_o    = push_i && !do_push;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= pop_ack_o;
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_ack_o) begin
        rptr_q    <= rptr_q + (AW+1)'(1);
        rd_data_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/rx_vc_credit_buffer.sv
// Per-VC receive buffer: class FIFOs, credit-limit counters, refresh timer and
// a round-robin UpdateFC scheduler toward the DLL TX path.
module rx_vc_credit_buffer
  import rx_fc_pkg::*;
#(
  parameter int NUM_CLASSES = 6,
  parameter int DATA_W      = 160,
  parameter int DEPTH       = 16,
  parameter int CREDIT_W    = CREDIT_W_DEF,
  parameter int CLS_W       = CLS_W_DEF,
  parameter int REFRESH_CYC = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  input  logic [CLS_W-1:0]                in_class_i,
  input  logic [DATA_W-1:0]               in_data_i,
  input  logic [NUM_CLASSES-1:0]          rd_en_i,
  output logic [NUM_CLASSES*DATA_W-1:0]   rd_data_o,
  output logic [NUM_CLASSES-1:0]          rd_valid_o,
  output logic [NUM_CLASSES-1:0]          empty_o,
  output logic [NUM_CLASSES-1:0]          full_o,
  output logic [NUM_CLASSES*CREDIT_W-1:0] credit_limit_o,
  output logic [NUM_CLASSES-1:0]          overflow_err_o,
  output logic                            updfc_valid_o,
  input  logic                            updfc_ready_i,
  output logic [CLS_W-1:0]                updfc_class_o,
  output logic [CREDIT_W-1:0]             updfc_limit_o
);
  localparam int TMR_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

  typedef struct packed {
    logic [CLS_W-1:0]    cls;
    logic [CREDIT_W-1:0] limit;
  } req_t;

  logic [NUM_CLASSES-1:0]               push, pop_ack, drop;
  logic [NUM_CLASSES-1:0][CREDIT_W-1:0] limit_q, limit_d;
  logic [NUM_CLASSES-1:0]               ovf_q, pend_q, pend_d;
  logic [CLS_W-1:0]                     ptr_q, ptr_d, gnt_idx;
  logic [CLS_W:0]                       scan;
  logic                                 gnt_vld, refresh_tc;
  fc_state_e                            state_q, state_d;
  req_t                                 req_q, req_d;

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cls
    // Out-of-range class IDs match no FIFO and are silently ignored.
    assign push[i] = in_valid_i && (in_class_i == CLS_W'(i));

    rx_class_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (push[i]),
      .wdata_i   (in_data_i),
      .pop_i     (rd_en_i[i]),
      .rd_data_o (rd_data_o[i*DATA_W +: DATA_W]),
      .rd_valid_o(rd_valid_o[i]),
      .empty_o   (empty_o[i]),
      .full_o    (full_o[i]),
      .pop_ack_o (pop_ack[i]),
      .drop_o    (drop[i])
    );
  end

  if (REFRESH_CYC == 0) begin : g_no_refresh
    assign refresh_tc = 1'b0;
  end else begin : g_refresh
    logic [TMR_W-1:0] tmr_q;
    assign refresh_tc = (tmr_q == TMR_W'(REFRESH_CYC - 1));
    always_ff @(posedge clk_i) begin
      if (rst_i || refresh_tc) tmr_q <= '0;
      else                     tmr_q <= tmr_q + TMR_W'(1);
    end
  end

  always_comb begin
    limit_d = limit_q;
    for (int i = 0; i < NUM_CLASSES; i++)
      if (pop_ack[i]) limit_d[i] = limit_q[i] + CREDIT_W'(1);
  end

  // Round-robin search: first pending class at or after the pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      scan = {1'b0, ptr_q} + (CLS_W+1)'(i);
      if (scan >= (CLS_W+1)'(NUM_CLASSES)) scan = scan - (CLS_W+1)'(NUM_CLASSES);
      if (!gnt_vld && pend_q[scan[CLS_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[CLS_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    pend_d  = pend_q;
    case (state_q)
      FC_IDLE: if (gnt_vld) begin
        state_d         = FC_OFFER;
        req_d.cls       = gnt_idx;
        req_d.limit     = limit_q[gnt_idx];
        pend_d[gnt_idx] = 1'b0;
        ptr_d = (gnt_idx == CLS_W'(NUM_CLASSES - 1)) ? '0 : gnt_idx + CLS_W'(1);
      end
      FC_OFFER: if (updfc_ready_i) state_d = FC_IDLE;
      default:  state_d = FC_IDLE;
    endcase
    // Setting after the grant clear keeps a same-cycle pop from being lost.
    pend_d = pend_d | pop_ack | {NUM_CLASSES{refresh_tc}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FC_IDLE;
      ptr_q   <= '0;
      req_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      limit_q <= {NUM_CLASSES{CREDIT_W'(DEPTH)}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_q | drop;
      limit_q <= limit_d;
    end
  end

  assign credit_limit_o = limit_q;
  assign overflow_err_o = ovf_q;
  assign updfc_valid_o  = (state_q == FC_OFFER);
  assign updfc_class_o  = req_q.cls;
  assign updfc_limit_o  = req_q.limit;
endmodule

// File: tb/tb_rx_vc_credit_buffer.sv
// Two instances (12-bit credits/no refresh, 5-bit credits/refresh 13) share stimulus
// and are compared every cycle against a queue-based behavioural model.
module tb_rx_vc_credit_buffer;
  import rx_fc_pkg::*;

  logic         clk = 1'b0;
  logic         rst, in_valid, updfc_ready;
  logic [2:0]   in_class;
  logic [159:0] in_data;
  logic [5:0]   rd_en;

  logic [959:0] a_rd_data, b_rd_data;
  logic [5:0]   a_rdv, a_emp, a_ful, a_ovf, b_rdv, b_emp, b_ful, b_ovf;
  logic [71:0]  a_cl;
  logic [29:0]  b_cl;
  logic         a_uv, b_uv;
  logic [2:0]   a_uc, b_uc;
  logic [11:0]  a_ul;
  logic [4:0]   b_ul;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rx_vc_credit_buffer #(.REFRESH_CYC(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_class_i(in_class), .in_data_i(in_data),
    .rd_en_i(rd_en), .rd_data_o(a_rd_data), .rd_valid_o(a_rdv), .empty_o(a_emp), .full_o(a_ful),
    .credit_limit_o(a_cl), .overflow_err_o(a_ovf), .updfc_valid_o(a_uv), .updfc_ready_i(updfc_ready),
    .updfc_class_o(a_uc), .updfc_limit_o(a_ul));

  rx_vc_credit_buffer #(.CREDIT_W(5), .REFRESH_CYC(13)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_class_i(in_class), .in_data_i(in_data),
    .rd_en_i(rd_en), .rd_data_o(b_rd_data), .rd_valid_o(b_rdv), .empty_o(b_emp), .full_o(b_ful),
    .credit_limit_o(b_cl), .overflow_err_o(b_ovf), .updfc_valid_o(b_uv), .updfc_ready_i(updfc_ready),
    .updfc_class_o(b_uc), .updfc_limit_o(b_ul));

  // ---------------- behavioural model ----------------
  logic [159:0] mq [2][6][$];
  logic [159:0] m_rdd [2][6];
  int  m_lim [2][6];
  bit  m_ovf [2][6], m_pend [2][6], m_rdv [2][6];
  int  m_ptr [2], m_tmr [2], m_ucls [2], m_ulim [2];
  bit  m_offer [2];
  updfc_t logA [$], logB [$];

  function automatic int cw(input int k); return k ? 5 : 12; endfunction
  function automatic int rf(input int k); return k ? 13 : 0; endfunction

  task automatic model_step(input int k);
    bit pop [6];
    bit tc;
    int g;
    if (rst) begin
      for (int c = 0; c < 6; c++) begin
        mq[k][c].delete();
        m_lim[k][c] = 16; m_ovf[k][c] = 0; m_pend[k][c] = 0; m_rdv[k][c] = 0; m_rdd[k][c] = '0;
      end
      m_ptr[k] = 0; m_tmr[k] = 0; m_offer[k] = 0; m_ucls[k] = 0; m_ulim[k] = 0;
      return;
    end
    for (int c = 0; c < 6; c++) pop[c] = rd_en[c] && (mq[k][c].size() != 0);
    if (!m_offer[k]) begin
      g = -1;
      for (int i = 0; i < 6; i++)
        if (g < 0 && m_pend[k][(m_ptr[k] + i) % 6]) g = (m_ptr[k] + i) % 6;
      if (g >= 0) begin
        m_ucls[k] = g; m_ulim[k] = m_lim[k][g]; m_pend[k][g] = 0;
        m_ptr[k] = (g + 1) % 6; m_offer[k] = 1;
      end
    end else if (updfc_ready) m_offer[k] = 0;
    tc = (rf(k) != 0) && (m_tmr[k] == rf(k) - 1);
    if (rf(k) != 0) m_tmr[k] = tc ? 0 : m_tmr[k] + 1;
    for (int c = 0; c < 6; c++) begin
      m_rdv[k][c] = pop[c];
      if (pop[c]) begin
        m_rdd[k][c] = mq[k][c].pop_front();
        m_lim[k][c] = (m_lim[k][c] + 1) % (1 << cw(k));
        m_pend[k][c] = 1;
      end
      if (tc) m_pend[k][c] = 1;
    end
    if (in_valid && in_class < 6) begin
      if (mq[k][in_class].size() < 16) mq[k][in_class].push_back(in_data);
      else m_ovf[k][in_class] = 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input int k, input logic [5:0] emp, input logic [5:0] ful, input logic [5:0] rdv,
                     input logic [5:0] ovf, input logic [959:0] rdd, input logic [71:0] cl,
                     input logic uv, input logic [2:0] uc, input logic [11:0] ul);
    logic [5:0]  e_emp, e_ful, e_rdv, e_ovf;
    logic [71:0] e_cl;
    string t;
    t = k ? "B" : "A";
    e_cl = '0;
    for (int c = 0; c < 6; c++) begin
      e_emp[c] = (mq[k][c].size() == 0);
      e_ful[c] = (mq[k][c].size() == 16);
      e_rdv[c] = m_rdv[k][c];
      e_ovf[c] = m_ovf[k][c];
      e_cl = e_cl | (72'(m_lim[k][c]) << (c * cw(k)));
    end
    chk({t, " empty"}, 192'(emp), 192'(e_emp));
    chk({t, " full"}, 192'(ful), 192'(e_ful));
    chk({t, " rd_valid"}, 192'(rdv), 192'(e_rdv));
    chk({t, " overflow_err"}, 192'(ovf), 192'(e_ovf));
    chk({t, " credit_limit"}, 192'(cl), 192'(e_cl));
    chk({t, " updfc_valid"}, 192'(uv), 192'(m_offer[k]));
    chk({t, " updfc_class"}, 192'(uc), 192'(m_ucls[k]));
    chk({t, " updfc_limit"}, 192'(ul), 192'(m_ulim[k]));
    for (int c = 0; c < 6; c++)
      if (e_rdv[c]) chk($sformatf("%s rd_data[%0d]", t, c), 192'(rdd[c*160 +: 160]), 192'(m_rdd[k][c]));
  endtask

  // Compare and handshake capture, a little after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      cmp(0, a_emp, a_ful, a_rdv, a_ovf, a_rd_data, a_cl, a_uv, a_uc, a_ul);
      cmp(1, b_emp, b_ful, b_rdv, b_ovf, b_rd_data, {42'd0, b_cl}, b_uv, b_uc, {7'd0, b_ul});
    end
    if (!rst && updfc_ready) begin
      if (a_uv) logA.push_back(mk(a_uc, a_ul));
      if (b_uv) logB.push_back(mk(b_uc, {7'd0, b_ul}));
    end
  end

  // ---------------- stimulus ----------------
  function automatic updfc_t mk(input logic [2:0] c, input logic [11:0] l);
    updfc_t u;
    u.cls = c; u.limit = l;
    return u;
  endfunction

  function automatic bit in_log(input updfc_t q [$], input updfc_t u);
    foreach (q[i]) if (q[i] == u) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit v, input logic [2:0] c, input logic [159:0] d, input logic [5:0] re);
    in_valid = v; in_class = c; in_data = d; rd_en = re;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; rd_en = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    logA.delete(); logB.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_class = '0; in_data = '0; rd_en = '0; updfc_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset credit_limit", 192'(a_cl), 192'({6{12'd16}}));
    chk("reset empty", 192'(a_emp), 192'(6'h3f));
    chk("reset rd_data", 192'(a_rd_data == '0), 192'(1));
    rst = 1'b0;
    idle(10);
    chk("idle updfc_valid", 192'(a_uv), 192'(0));

    // Push three to PD, pop one.
    step(1, 3'd1, 160'h0A1, 6'h00);
    step(1, 3'd1, 160'h0A2, 6'h00);
    step(1, 3'd1, 160'h0A3, 6'h00);
    step(1, 3'd7, 160'hDEAD, 6'h00);
    step(0, 3'd0, 160'h0, 6'b000010);
    chk("pop rd_valid", 192'(a_rdv), 192'(6'b000010));
    chk("pop rd_data", 192'(a_rd_data[1*160 +: 160]), 192'(160'h0A1));
    chk("pop credit_limit[1]", 192'(a_cl[1*12 +: 12]), 192'(17));
    idle(1);
    chk("updfc offer valid", 192'(a_uv), 192'(1));
    chk("updfc offer payload", 192'(mk(a_uc, a_ul)), 192'(mk(3'd1, 12'd17)));
    idle(3);
    chk("updfc log size", 192'(logA.size()), 192'(1));

    // Fill PH past capacity, then push+pop while full, then drain.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      step(1, 3'd0, 160'(i), 6'h00);
      if (i == 16) chk("full after 16", 192'({a_ful[0], a_ovf[0]}), 192'(2'b10));
      if (i == 17) chk("overflow on 17", 192'({a_ful[0], a_ovf[0]}), 192'(2'b11));
    end
    step(1, 3'd0, 160'h99, 6'b000001);
    chk("push+pop when full", 192'({a_ful[0], a_rd_data[159:0]}), 192'({1'b1, 160'd1}));
    for (int j = 0; j < 16; j++) begin
      step(0, 3'd0, 160'h0, 6'b000001);
      if (j == 14) chk("drain data 16", 192'(a_rd_data[159:0]), 192'(16));
      if (j == 15) chk("drain last", 192'(a_rd_data[159:0]), 192'(160'h99));
    end
    step(0, 3'd0, 160'h0, 6'b000001);
    chk("pop on empty", 192'({a_rdv[0], a_emp[0], a_ovf[0]}), 192'(3'b011));
    chk("credit_limit[0] after 17 pops", 192'(a_cl[11:0]), 192'(33));

    // Simultaneous pops on PH, NPH, CplD with the pointer at 0.
    do_reset();
    step(1, 3'd0, 160'hC0, 6'h00);
    step(1, 3'd2, 160'hC2, 6'h00);
    step(1, 3'd5, 160'hC5, 6'h00);
    step(0, 3'd0, 160'h0, 6'b100101);
    idle(10);
    chk("rr order count", 192'(logA.size()), 192'(3));
    chk("rr order #0", 192'((logA.size() > 0) ? logA[0] : '1), 192'(mk(3'd0, 12'd17)));
    chk("rr order #1", 192'((logA.size() > 1) ? logA[1] : '1), 192'(mk(3'd2, 12'd17)));
    chk("rr order #2", 192'((logA.size() > 2) ? logA[2] : '1), 192'(mk(3'd5, 12'd17)));

    // Backpressure on NPD with further pops while the offer is held.
    updfc_ready = 1'b0;
    logA.delete();
    step(1, 3'd3, 160'hD1, 6'h00);
    step(1, 3'd3, 160'hD2, 6'h00);
    step(1, 3'd3, 160'hD3, 6'h00);
    step(0, 3'd0, 160'h0, 6'b001000);
    idle(1);
    for (int j = 0; j < 5; j++) begin
      step(0, 3'd0, 160'h0, (j < 2) ? 6'b001000 : 6'b000000);
      chk("held offer", 192'({a_uv, a_uc, a_ul}), 192'({1'b1, 3'd3, 12'd17}));
    end
    chk("credit_limit[3] while held", 192'(a_cl[3*12 +: 12]), 192'(19));
    updfc_ready = 1'b1;
    idle(6);
    chk("held log size", 192'(logA.size()), 192'(2));
    chk("held first", 192'((logA.size() > 0) ? logA[0] : '1), 192'(mk(3'd3, 12'd17)));
    chk("held latest", 192'((logA.size() > 1) ? logA[1] : '1), 192'(mk(3'd3, 12'd19)));

    // Credit wrap on CplH: 16 pops takes the 5-bit counter 16 -> 31 -> 0.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 3'd4, 160'(i + 'h40), 6'h00);
    for (int j = 0; j < 16; j++) begin
      step(0, 3'd0, 160'h0, 6'b010000);
      if (j == 14) chk("B credit 31", 192'(b_cl[4*5 +: 5]), 192'(31));
    end
    chk("B credit wrap", 192'(b_cl[4*5 +: 5]), 192'(0));
    chk("A credit 32", 192'(a_cl[4*12 +: 12]), 192'(32));
    idle(20);
    chk("B updfc limit 0", 192'(in_log(logB, mk(3'd4, 12'd0))), 192'(1));
    chk("A updfc limit 32", 192'(in_log(logA, mk(3'd4, 12'd32))), 192'(1));

    // Reset while an UpdateFC is being offered.
    step(1, 3'd2, 160'hE2, 6'h00);
    updfc_ready = 1'b0;
    step(0, 3'd0, 160'h0, 6'b000100);
    idle(1);
    chk("pre-reset offer", 192'(a_uv), 192'(1));
    rst = 1'b1;
    idle(1);
    chk("mid reset updfc", 192'({a_uv, a_uc, a_ul, b_uv, b_uc, b_ul}), 192'(0));
    chk("mid reset credit A", 192'(a_cl), 192'({6{12'd16}}));
    chk("mid reset credit B", 192'(b_cl), 192'({6{5'd16}}));
    chk("mid reset flags", 192'({a_emp, a_ful, a_ovf, a_rdv}), 192'({6'h3f, 18'd0}));
    chk("mid reset rd_data", 192'(a_rd_data == '0), 192'(1));
    rst = 1'b0;
    updfc_ready = 1'b1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
